multi_channel_debounce_ff: RTL

//  Parametrised successor to the single-bit flip-flop: a bank of WIDTH registered channels.

---
 rtl/multi_channel_debounce_ff.sv | 113 +++++++++++
 1 files changed

// File: rtl/multi_channel_debounce_ff.sv
// ----------------------------------------------------------------------------
// multi_channel_debounce_ff
//
// Bank of WIDTH independent debounced flip-flop channels. Each channel passes
// its raw pin through an N-stage synchroniser and then through a stability
// counter. The held output Q only changes after the synchronised input has
// differed from Q for DEBOUNCE_CNT consecutive enabled ticks. Registered
// one-cycle rise/fall pulses mark each Q transition.
//
// Ports
//   C        in   1      clock, all state updates on posedge
//   reset    in   1      synchronous active-high reset, dominates everything
//   enable   in   1      sample tick; debounce counters advance only when 1
//   D        in   WIDTH  raw asynchronous inputs
//   Q        out  WIDTH  debounced registered outputs
//   notQ     out  WIDTH  ~Q
//   rise     out  WIDTH  1-cycle pulse in the cycle Q[i] goes 0->1
//   fall     out  WIDTH  1-cycle pulse in the cycle Q[i] goes 1->0
//   changed  out  1      OR of all rise/fall pulses
// ----------------------------------------------------------------------------
module multi_channel_debounce_ff #(
   parameter int   WIDTH        = 4,
   parameter int   SYNC_STAGES  = 2,
   parameter int   DEBOUNCE_CNT = 8,
   parameter logic RESET_LEVEL  = 1'b0
) (
   input  logic             C,
   input  logic             reset,
   input  logic             enable,
   input  logic [WIDTH-1:0] D,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] notQ,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   // Synchroniser chain: stage 0 captures the raw pins, the last stage is
   // the metastability-filtered view used by the debounce logic.
   logic [WIDTH-1:0] sync_reg [SYNC_STAGES];

   always_ff @(posedge C) begin
      if (reset) begin
         sync_reg[0] <= {WIDTH{RESET_LEVEL}};
      end else begin
         sync_reg[0] <= D;
      end
   end

   genvar gi;
   generate
      for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
         always_ff @(posedge C) begin
            if (reset) begin
               sync_reg[gi] <= {WIDTH{RESET_LEVEL}};
            end else begin
               sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   logic [WIDTH-1:0] s;
   assign s = sync_reg[SYNC_STAGES-1];

   // Per-channel debounce state. Each channel keeps its own registers so the
   // channels are fully independent.
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_chan
         logic [CNT_W-1:0] cnt_reg;
         logic             q_reg;
         logic             rise_reg;
         logic             fall_reg;

         always_ff @(posedge C) begin
            if (reset) begin
               cnt_reg  <= '0;
               q_reg    <= RESET_LEVEL;
               rise_reg <= 1'b0;
               fall_reg <= 1'b0;
            end else begin
               rise_reg <= 1'b0;
               fall_reg <= 1'b0;
               if (s[gi] == q_reg) begin
                  // Input agrees with the held value: any partial count
                  // was a glitch and is discarded.
                  cnt_reg <= '0;
               end else if (!enable) begin
                  cnt_reg <= cnt_reg;
               end else if (cnt_reg == CNT_LAST) begin
                  q_reg    <= s[gi];
                  cnt_reg  <= '0;
                  rise_reg <= s[gi];
                  fall_reg <= ~s[gi];
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
         end

         assign Q[gi]    = q_reg;
         assign rise[gi] = rise_reg;
         assign fall[gi] = fall_reg;
      end
   endgenerate

   assign notQ    = ~Q;
   assign changed = |(rise | fall);

endmodule
